// File: rtl/mem_system_wb.sv
// mem_system_wb: write-back miss controller between a pipeline memory port,
// one direct-mapped cache array and a banked, pipelined main memory.
// Hits finish in the lookup cycle; misses evict a dirty victim, refill with
// back-to-back pipelined reads, then repeat the lookup.
// Optional build macro: MEMSYS_STATS_EN (hit/miss statistics counters).
module mem_system_wb #(
  parameter int DATA_W        = 16,
  parameter int TAG_W         = 5,
  parameter int INDEX_W       = 8,
  parameter int WORDS_PER_BLK = 4,
  parameter int MEM_LAT       = 2,
  parameter int ADDR_W        = 16,
  localparam int OFF_W        = $clog2(WORDS_PER_BLK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic               Rd,
  input  logic               Wr,
  output logic [DATA_W-1:0]  DataOut,
  output logic               Done,
  output logic               Stall,
  output logic               CacheHit,
  output logic               err,
  output logic               c_enable,
  output logic               c_comp,
  output logic               c_write,
  output logic               c_valid_in,
  output logic [TAG_W-1:0]   c_tag_in,
  output logic [INDEX_W-1:0] c_index,
  output logic [OFF_W:0]     c_offset,
  output logic [DATA_W-1:0]  c_data_in,
  input  logic [TAG_W-1:0]   c_tag_out,
  input  logic [DATA_W-1:0]  c_data_out,
  input  logic               c_hit,
  input  logic               c_dirty,
  input  logic               c_valid,
  input  logic               c_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data_in,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [DATA_W-1:0]  mem_data_out,
  input  logic               mem_stall,
  input  logic               mem_err,
  output logic [15:0]        HitCount,
  output logic [15:0]        MissCount
);

  typedef enum logic [2:0] {IDLE, EVICT, FILL, RETRY, ERR} state_t;

  localparam logic [OFF_W:0]   N_FULL = (OFF_W+1)'(WORDS_PER_BLK);
  localparam logic [OFF_W:0]   N_LAST = (OFF_W+1)'(WORDS_PER_BLK - 1);
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(WORDS_PER_BLK - 1);

  state_t                          r_state;
  logic [OFF_W-1:0]                r_k;          // evict word
  logic [OFF_W:0]                  r_issue;      // fill reads issued
  logic [OFF_W:0]                  r_inst;       // fill words installed
  logic [DATA_W-1:0]               r_dout;
  logic [MEM_LAT-1:0]              r_vld_pipe;   // accepted reads in flight
  logic [MEM_LAT-1:0][OFF_W-1:0]   r_off_pipe;   // their block offsets

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic               w_req, w_bad, w_lookup, w_hit, w_xerr;
  logic               w_issue, w_install, w_idle_miss;

  assign w_tag       = Addr[ADDR_W-1 -: TAG_W];
  assign w_idx       = Addr[ADDR_W-TAG_W-1 -: INDEX_W];
  assign w_req       = Rd | Wr;
  assign w_bad       = (Rd & Wr) | Addr[0];
  assign w_lookup    = !rst && w_req && !w_bad && (r_state == IDLE || r_state == RETRY);
  assign w_hit       = w_lookup & c_hit & c_valid;
  assign w_xerr      = c_err | mem_err;
  assign w_issue     = !rst && (r_state == FILL) && (r_issue < N_FULL);
  assign w_install   = !rst && (r_state == FILL) && r_vld_pipe[MEM_LAT-1];
  assign w_idle_miss = (r_state == IDLE) & w_lookup & !w_hit;

  // Read data is live on the hit cycle, then held from the register
  assign DataOut = (Done & Rd) ? c_data_out : r_dout;
  assign err     = (r_state == ERR);

  // Cache and memory controls decoded from state for the current cycle
  always_comb begin
    c_enable    = 1'b0;
    c_comp      = 1'b0;
    c_write     = 1'b0;
    c_valid_in  = 1'b0;
    c_tag_in    = w_tag;
    c_index     = w_idx;
    c_offset    = Addr[OFF_W:0];
    c_data_in   = DataIn;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    Done        = 1'b0;
    CacheHit    = 1'b0;
    Stall       = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_lookup) begin
            c_enable   = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = 1'b1;
            Done       = w_hit;
            CacheHit   = w_hit;
            Stall      = !w_hit;
          end
        end
        EVICT: begin
          Stall       = 1'b1;
          c_enable    = 1'b1;
          c_offset    = {r_k, 1'b0};
          mem_wr      = 1'b1;
          mem_addr    = {c_tag_out, w_idx, r_k, 1'b0};
          mem_data_in = c_data_out;
        end
        FILL: begin
          Stall    = 1'b1;
          mem_rd   = w_issue;
          mem_addr = {w_tag, w_idx, r_issue[OFF_W-1:0], 1'b0};
          if (w_install) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_offset   = {r_off_pipe[MEM_LAT-1], 1'b0};
            c_data_in  = mem_data_out;
          end
        end
        RETRY: begin
          Stall = 1'b1;
          if (w_lookup) begin
            c_enable   = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = 1'b1;
            Done       = w_hit;
          end
        end
        default: ;
      endcase
    end
  end

  // Miss FSM with evict/issue/install counters and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_issue <= '0;
      r_inst  <= '0;
      r_dout  <= '0;
    end else begin
      if (Done & Rd) r_dout <= c_data_out;
      case (r_state)
        IDLE: begin
          if (w_req & w_bad) r_state <= ERR;
          else if (w_idle_miss) begin
            r_state <= (c_valid & c_dirty) ? EVICT : FILL;
            r_k     <= '0;
            r_issue <= '0;
            r_inst  <= '0;
          end
        end
        EVICT: begin
          if (!mem_stall) begin
            r_k <= r_k + 1'b1;
            if (r_k == K_LAST) r_state <= FILL;
          end
        end
        FILL: begin
          if (w_issue & !mem_stall) r_issue <= r_issue + 1'b1;
          if (w_install) begin
            r_inst <= r_inst + 1'b1;
            if (r_inst == N_LAST) r_state <= RETRY;
          end
        end
        RETRY:   r_state <= (w_lookup & !w_hit) ? ERR : IDLE;
        default: r_state <= ERR;
      endcase
      if (w_xerr) r_state <= ERR;
    end
  end

  // Track accepted reads until their data returns; cleared so rst drops in-flight reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_off_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= mem_rd & !mem_stall;
      r_off_pipe[0] <= r_issue[OFF_W-1:0];
      for (int s = 1; s < MEM_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_off_pipe[s] <= r_off_pipe[s-1];
      end
    end
  end

`ifdef MEMSYS_STATS_EN
  logic [15:0] r_hits, r_miss;

  // Saturating hit/miss statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hits <= '0;
      r_miss <= '0;
    end else begin
      if (Done & CacheHit & (r_hits != 16'hFFFF)) r_hits <= r_hits + 1'b1;
      if (w_idle_miss & (r_miss != 16'hFFFF))     r_miss <= r_miss + 1'b1;
    end
  end

  assign HitCount  = r_hits;
  assign MissCount = r_miss;
`else
  assign HitCount  = 16'h0000;
  assign MissCount = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_system_wb.sv
// tb_mem_system_wb: directed bench with behavioural cache array and pipelined memory.
// Untouched memory word at address A reads as ~A.
module tb_mem_system_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0, DataIn = '0;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic        c_enable, c_comp, c_write, c_valid_in;
  logic [4:0]  c_tag_in, c_tag_out;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in, c_data_out;
  logic        c_hit, c_dirty, c_valid;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr, mem_rd;
  logic        mem_stall = 1'b0;
  logic [15:0] HitCount, MissCount;
  logic        cinit = 1'b1;

  int n_chk = 0, n_fail = 0;

  mem_system_wb dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_tag_in(c_tag_in), .c_index(c_index), .c_offset(c_offset), .c_data_in(c_data_in),
    .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_hit(c_hit), .c_dirty(c_dirty),
    .c_valid(c_valid), .c_err(1'b0),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .mem_err(1'b0),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // cache array model
  logic [255:0] cv, cdty;
  logic [4:0]   ctag [0:255];
  logic [15:0]  cdat [0:255][0:3];

  always_comb begin
    c_tag_out  = ctag[c_index];
    c_valid    = cv[c_index];
    c_dirty    = cdty[c_index];
    c_data_out = cdat[c_index][c_offset[2:1]];
    c_hit      = c_enable & c_comp & cv[c_index] & (ctag[c_index] == c_tag_in);
  end

  always @(posedge clk) begin
    if (cinit) begin
      cv   <= '0;
      cdty <= '0;
    end else if (c_enable & c_write) begin
      if (c_comp) begin
        if (c_hit) begin
          cdat[c_index][c_offset[2:1]] <= c_data_in;
          cdty[c_index] <= 1'b1;
        end
      end else begin
        cdat[c_index][c_offset[2:1]] <= c_data_in;
        ctag[c_index] <= c_tag_in;
        cv[c_index]   <= c_valid_in;
        cdty[c_index] <= 1'b0;
      end
    end
  end

  // main memory model with request log
  logic [15:0] mem [int];
  int          cyc_ctr = 0, rd_tot = 0, wr_tot = 0;
  int          rd_cyc [int];
  logic [15:0] wr_adr [int];
  logic [15:0] rp0 = '0, rp1 = '0;

  function automatic logic [15:0] memrd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : ~a;
  endfunction

  always @(posedge clk) begin
    cyc_ctr = cyc_ctr + 1;
    if (mem_wr && !mem_stall) begin
      mem[int'(mem_addr)] = mem_data_in;
      wr_adr[wr_tot] = mem_addr;
      wr_tot = wr_tot + 1;
    end
    if (mem_rd && !mem_stall) begin
      rd_cyc[rd_tot] = cyc_ctr;
      rd_tot = rd_tot + 1;
    end
  end

  always @(posedge clk) begin
    rp0 <= (mem_rd && !mem_stall) ? memrd(mem_addr) : 16'h0000;
    rp1 <= rp0;
  end
  assign mem_data_out = rp1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // issue one request, return cycles to Done (1 = lookup cycle), CacheHit and DataOut
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int cyc, output logic hit, output logic [15:0] dout);
    @(negedge clk);
    Addr = a; DataIn = d; Rd = rd; Wr = wr;
    cyc = 0; hit = 1'b0; dout = '0;
    for (int n = 1; n <= 100; n++) begin
      #1;
      if (Done) begin
        cyc = n; hit = CacheHit; dout = DataOut;
        break;
      end
      @(negedge clk);
    end
    if (cyc == 0) chk("timeout", {31'd0, Done}, 32'd1);
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
  endtask

`ifdef MEMSYS_STATS_EN
  localparam logic [15:0] EXP_H = 16'd3, EXP_M = 16'd4;
`else
  localparam logic [15:0] EXP_H = 16'd0, EXP_M = 16'd0;
`endif

  int          cyc, rb, wb;
  logic        hit;
  logic [15:0] dout;

  initial begin
    repeat (3) @(negedge clk);
    cinit = 1'b0;
    rst   = 1'b0;
    #1;
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dout", {16'd0, DataOut}, 32'd0);
    chk("rst_memreq", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_hitcnt", {16'd0, HitCount}, 32'd0);
    chk("rst_misscnt", {16'd0, MissCount}, 32'd0);

    // clean read miss
    rb = rd_tot; wb = wr_tot;
    do_req(1'b1, 1'b0, 16'h0004, 16'h0, cyc, hit, dout);
    chk("miss_lat", cyc, 32'd8);
    chk("miss_hit", {31'd0, hit}, 32'd0);
    chk("miss_dout", {16'd0, dout}, 32'h0000FFFB);
    chk("miss_nrd", rd_tot - rb, 32'd4);
    chk("miss_rdspan", rd_cyc[rb+3] - rd_cyc[rb], 32'd3);
    chk("miss_nwr", wr_tot - wb, 32'd0);

    // same read hits
    do_req(1'b1, 1'b0, 16'h0004, 16'h0, cyc, hit, dout);
    chk("hit_lat", cyc, 32'd1);
    chk("hit_hit", {31'd0, hit}, 32'd1);
    chk("hit_dout", {16'd0, dout}, 32'h0000FFFB);

    // write miss, then conflicting read evicts the dirty block
    do_req(1'b0, 1'b1, 16'h0102, 16'hBEEF, cyc, hit, dout);
    chk("wr_lat", cyc, 32'd8);
    chk("wr_hit", {31'd0, hit}, 32'd0);
    chk("wr_douthold", {16'd0, dout}, 32'h0000FFFB);
    wb = wr_tot;
    do_req(1'b1, 1'b0, 16'h2102, 16'h0, cyc, hit, dout);
    chk("dirty_lat", cyc, 32'd12);
    chk("dirty_dout", {16'd0, dout}, 32'h0000DEFD);
    chk("dirty_nwr", wr_tot - wb, 32'd4);
    for (int k = 0; k < 4; k++)
      chk("dirty_wadr", {16'd0, wr_adr[wb+k]}, 32'h100 + 32'(2*k));
    chk("mem_0102", {16'd0, memrd(16'h0102)}, 32'h0000BEEF);
    chk("mem_0100", {16'd0, memrd(16'h0100)}, 32'h0000FEFF);

    // mem_stall for 3 cycles during FILL
    rb = rd_tot;
    fork
      do_req(1'b1, 1'b0, 16'h0400, 16'h0, cyc, hit, dout);
      begin
        repeat (3) @(negedge clk);
        mem_stall = 1'b1;
        repeat (3) @(negedge clk);
        mem_stall = 1'b0;
      end
    join
    chk("stall_lat", cyc, 32'd11);
    chk("stall_dout", {16'd0, dout}, 32'h0000FBFF);
    chk("stall_nrd", rd_tot - rb, 32'd4);
    do_req(1'b1, 1'b0, 16'h0402, 16'h0, cyc, hit, dout);
    chk("stall_w1", {15'd0, hit, dout}, 32'h0001FBFD);
    do_req(1'b1, 1'b0, 16'h0406, 16'h0, cyc, hit, dout);
    chk("stall_w3", {15'd0, hit, dout}, 32'h0001FBF9);

    #1;
    chk("stat_hits", {16'd0, HitCount}, {16'd0, EXP_H});
    chk("stat_miss", {16'd0, MissCount}, {16'd0, EXP_M});

    // Rd&Wr error, sticky until rst
    @(negedge clk);
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0000;
    #1;
    chk("err_pre", {31'd0, err}, 32'd0);
    chk("err_done", {31'd0, Done}, 32'd0);
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    #1;
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("err_stick", {31'd0, err}, 32'd1);
    chk("err_nomem", {30'd0, mem_rd, mem_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_clr", {31'd0, err}, 32'd0);
    chk("err_hitclr", {16'd0, HitCount}, 32'd0);
    do_req(1'b1, 1'b0, 16'h0004, 16'h0, cyc, hit, dout);
    chk("post_rst_hit", {15'd0, hit, dout}, 32'h0001FFFB);
    chk("post_rst_lat", cyc, 32'd1);

    // odd address error
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0005;
    @(negedge clk);
    Rd = 1'b0;
    #1;
    chk("err_odd", {31'd0, err}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_odd_clr", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
